// File: rtl/ssd_scan_decoder.sv
// Receive-side decoder for a multiplexed, active-low seven-segment scan.
// Rebuilds the displayed hex value, flags bad slots and counts completed frames.
module ssd_scan_decoder #(
  parameter int N_DIGITS   = 4,
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [7:0]       An,
  input  logic [7:0]       Cath,
  output logic [31:0]      digits,
  output logic [7:0]       digit_valid,
  output logic [7:0]       dp_lit,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_count,
  output logic             err_pattern,
  output logic             err_multi
);

  localparam int SC_W = $clog2(SETTLE_CYC);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(SETTLE_CYC - 1);

  // Returns {legal, value} for an abcdefg pattern where 0 means lit.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'b0000001: seg_decode = 5'h10;
      7'b1001111: seg_decode = 5'h11;
      7'b0010010: seg_decode = 5'h12;
      7'b0000110: seg_decode = 5'h13;
      7'b1001100: seg_decode = 5'h14;
      7'b0100100: seg_decode = 5'h15;
      7'b0100000: seg_decode = 5'h16;
      7'b0001111: seg_decode = 5'h17;
      7'b0000000: seg_decode = 5'h18;
      7'b0000100: seg_decode = 5'h19;
      7'b0001000: seg_decode = 5'h1A;
      7'b1100000: seg_decode = 5'h1B;
      7'b0110001: seg_decode = 5'h1C;
      7'b1000010: seg_decode = 5'h1D;
      7'b0110000: seg_decode = 5'h1E;
      7'b0111000: seg_decode = 5'h1F;
      default:    seg_decode = 5'h00;
    endcase
  endfunction

  logic [15:0]         s1_q, s2_q;
  logic [SC_W-1:0]     cnt_q, cnt_d;
  logic                captured_q, captured_d;
  logic [N_DIGITS-1:0] seen_q, seen_d;
  logic [N_DIGITS-1:0] anode_low;
  logic [31:0]         digits_q, digits_d;
  logic [7:0]          valid_q, valid_d;
  logic [7:0]          dp_q, dp_d;
  logic                frame_done_q, frame_done_d;
  logic [CNT_W-1:0]    frame_count_q, frame_count_d;
  logic                err_pattern_q, err_pattern_d;
  logic                err_multi_q, err_multi_d;
  logic [3:0]          n_low;
  logic [4:0]          dec;
  logic                settled;
  logic                frame_fire;

  always_comb begin
    n_low = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      anode_low[i] = ~s2_q[8+i];
      n_low        = n_low + 4'(anode_low[i]);
    end
  end

  assign dec        = seg_decode(s2_q[7:1]);
  assign settled    = (cnt_q == SC_MAX) && !captured_q;
  assign frame_fire = &seen_q;

  always_comb begin
    cnt_d         = cnt_q;
    captured_d    = captured_q | settled;
    digits_d      = digits_q;
    valid_d       = valid_q;
    dp_d          = dp_q;
    err_pattern_d = 1'b0;
    err_multi_d   = 1'b0;
    frame_done_d  = frame_fire;
    frame_count_d = frame_count_q + CNT_W'(frame_fire);
    // A capture on the frame edge lands in the freshly cleared mask.
    seen_d        = frame_fire ? '0 : seen_q;

    if (s1_q != s2_q) begin
      cnt_d      = '0;
      captured_d = 1'b0;
    end else if (cnt_q != SC_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (settled) begin
      if (n_low >= 4'd2) begin
        err_multi_d = 1'b1;
      end else if (n_low == 4'd1) begin
        for (int i = 0; i < N_DIGITS; i++) begin
          if (anode_low[i]) begin
            seen_d[i] = 1'b1;
            if (dec[4]) begin
              digits_d[4*i +: 4] = dec[3:0];
              valid_d[i]         = 1'b1;
              dp_d[i]            = ~s2_q[0];
            end else begin
              valid_d[i]    = 1'b0;
              err_pattern_d = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_q          <= 16'hFFFF;
      s2_q          <= 16'hFFFF;
      cnt_q         <= '0;
      captured_q    <= 1'b0;
      seen_q        <= '0;
      digits_q      <= '0;
      valid_q       <= '0;
      dp_q          <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_pattern_q <= 1'b0;
      err_multi_q   <= 1'b0;
    end else begin
      s1_q          <= {An, Cath};
      s2_q          <= s1_q;
      cnt_q         <= cnt_d;
      captured_q    <= captured_d;
      seen_q        <= seen_d;
      digits_q      <= digits_d;
      valid_q       <= valid_d;
      dp_q          <= dp_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      err_pattern_q <= err_pattern_d;
      err_multi_q   <= err_multi_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign dp_lit      = dp_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign err_pattern = err_pattern_q;
  assign err_multi   = err_multi_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed and randomized bench for ssd_scan_decoder, with a table-lookup
// reference model of the displayed value, frame count and error pulses.
module tb_ssd_scan_decoder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  An, Cath;
  logic [31:0] digits;
  logic [7:0]  digit_valid, dp_lit;
  logic        frame_done, err_pattern, err_multi;
  logic [15:0] frame_count;

  int tests = 0;
  int fails = 0;
  int n_pat = 0, n_multi = 0, n_frame = 0;

  // Decoded value k is the table entry at index k (abcdefg, 0 = lit).
  logic [6:0] tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic [15:0] m_digits;
  logic [3:0]  m_valid, m_dp, m_seen;
  int          m_frames, m_pat, m_multi;
  int          b_pat, b_multi, b_frame;

  ssd_scan_decoder dut (
    .Clk(Clk), .Reset(Reset), .An(An), .Cath(Cath),
    .digits(digits), .digit_valid(digit_valid), .dp_lit(dp_lit),
    .frame_done(frame_done), .frame_count(frame_count),
    .err_pattern(err_pattern), .err_multi(err_multi)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (!Reset) begin
      if (err_pattern) n_pat++;
      if (err_multi)   n_multi++;
      if (frame_done)  n_frame++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge Clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_digits = '0; m_valid = '0; m_dp = '0; m_seen = '0;
    m_frames = 0; m_pat = 0; m_multi = 0;
    b_pat = n_pat; b_multi = n_multi; b_frame = n_frame;
  endtask

  // One settled slot, evaluated from the decoding rules directly.
  task automatic model_dwell(input logic [7:0] an, input logic [7:0] ca);
    logic [3:0] low;
    int n, idx, v;
    low = ~an[3:0];
    n = $countones(low);
    idx = 0;
    v = -1;
    for (int k = 0; k < 4; k++) if (low[k]) idx = k;
    for (int k = 0; k < 16; k++) if (tbl[k] == ca[7:1]) v = k;
    if (n >= 2) begin
      m_multi++;
    end else if (n == 1) begin
      if (v >= 0) begin
        m_digits[4*idx +: 4] = 4'(v);
        m_valid[idx] = 1'b1;
        m_dp[idx] = ~ca[0];
      end else begin
        m_pat++;
        m_valid[idx] = 1'b0;
      end
      m_seen[idx] = 1'b1;
      if (m_seen == 4'hF) begin
        m_frames++;
        m_seen = '0;
      end
    end
  endtask

  task automatic check_model(input int d);
    string s;
    s = $sformatf("rnd%0d", d);
    check({s, "_digits"}, digits, {16'h0, m_digits});
    check({s, "_valid"}, 32'(digit_valid), {28'h0, m_valid});
    check({s, "_dp"}, 32'(dp_lit), {28'h0, m_dp});
    check({s, "_fcount"}, 32'(frame_count), 32'(m_frames));
    check({s, "_nframe"}, 32'(n_frame - b_frame), 32'(m_frames));
    check({s, "_npat"}, 32'(n_pat - b_pat), 32'(m_pat));
    check({s, "_nmulti"}, 32'(n_multi - b_multi), 32'(m_multi));
  endtask

  initial begin : stim
    logic [7:0]  an_seq [4];
    logic [7:0]  ca_seq [4];
    logic [7:0]  an, ca;
    logic [15:0] prev;
    int p0, m0, f0, tot0, len, kind, a, b;

    an_seq = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
    ca_seq = '{8'h9F, 8'h25, 8'h0C, 8'h99};

    // Reset with arbitrary inputs, then release with the display blanked.
    Reset = 1'b1;
    An = 8'($urandom);
    Cath = 8'($urandom);
    tick(3);
    check("rst_hold", {digits[15:0], digit_valid, dp_lit}, 32'h0);
    Reset = 1'b0;
    An = 8'hFF;
    Cath = 8'hFF;
    check("rst_release", {frame_count, 13'h0, frame_done, err_pattern, err_multi}, 32'h0);
    tot0 = n_pat + n_multi + n_frame;
    tick(100);
    check("blank_no_pulse", 32'(n_pat + n_multi + n_frame - tot0), 32'h0);

    // Digit 7 on position 0: capture lands exactly on edge 18.
    An = 8'hFE;
    Cath = 8'b00011111;
    tick(17);
    check("pre_edge18_valid", 32'(digit_valid), 32'h0);
    tick(1);
    check("edge18_digit", 32'(digits[3:0]), 32'h7);
    check("edge18_valid", 32'(digit_valid), 32'h01);
    check("edge18_dp", 32'(dp_lit), 32'h0);
    check("edge18_noframe", 32'(n_frame), 32'h0);
    tick(182);
    check("hold_valid", 32'(digit_valid), 32'h01);
    check("hold_no_pulse", 32'(n_pat + n_multi + n_frame - tot0), 32'h0);

    // Dwell too short to settle.
    An = 8'hFD;
    Cath = 8'b01001001;
    tick(10);
    An = 8'hFF;
    Cath = 8'hFF;
    tick(30);
    check("short_valid", 32'(digit_valid), 32'h01);

    // Two full scans of 1,2,3,4 with Dp lit on digit 2.
    f0 = n_frame;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 4; k++) begin
        An = an_seq[k];
        Cath = ca_seq[k];
        tick(30);
      end
      check("scan_digits", 32'(digits[15:0]), 32'h4321);
      check("scan_valid", 32'(digit_valid), 32'h0F);
      check("scan_dp", 32'(dp_lit), 32'h04);
      check("scan_fcount", 32'(frame_count), 32'(s + 1));
      check("scan_npulse", 32'(n_frame - f0), 32'(s + 1));
    end

    // Blank pattern on a selected digit, then two anodes low.
    p0 = n_pat;
    m0 = n_multi;
    An = 8'hFD;
    Cath = 8'hFF;
    tick(30);
    check("blankpat_err", 32'(n_pat - p0), 32'h1);
    check("blankpat_valid", 32'(digit_valid), 32'h0D);
    An = 8'hFC;
    tick(30);
    check("multi_err", 32'(n_multi - m0), 32'h1);
    check("multi_digits", digits, 32'h4321);
    check("multi_nopat", 32'(n_pat - p0), 32'h1);

    // Reset mid-dwell: a full settle is needed again afterwards.
    An = 8'hFE;
    Cath = 8'b01001001;
    tick(5);
    Reset = 1'b1;
    tick(2);
    check("midrst_digits", digits, 32'h0);
    Reset = 1'b0;
    tick(17);
    check("midrst_pre18", 32'(digit_valid), 32'h0);
    tick(1);
    check("midrst_digit", 32'(digits[3:0]), 32'h5);
    check("midrst_valid", 32'(digit_valid), 32'h01);
    check("midrst_fcount", 32'(frame_count), 32'h0);

    // Randomized dwells against the reference model.
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    An = 8'hFF;
    Cath = 8'hFF;
    model_reset();
    prev = 16'hFFFF;
    tick(20);
    for (int d = 0; d < 40; d++) begin
      do begin
        kind = $urandom_range(0, 9);
        an[7:4] = 4'($urandom);
        if (kind == 0) begin
          an[3:0] = 4'hF;
        end else if (kind == 1) begin
          a = $urandom_range(0, 3);
          b = (a + 1 + $urandom_range(0, 2)) % 4;
          an[3:0] = ~((4'b1 << a) | (4'b1 << b));
        end else begin
          an[3:0] = ~(4'b1 << $urandom_range(0, 3));
        end
        if ($urandom_range(0, 3) == 0) ca[7:1] = 7'($urandom);
        else ca[7:1] = tbl[$urandom_range(0, 15)];
        ca[0] = 1'($urandom);
      end while ({an, ca} == prev);
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 15) : $urandom_range(20, 40);
      An = an;
      Cath = ca;
      prev = {an, ca};
      tick(len);
      if (len >= 20) begin
        model_dwell(an, ca);
        check_model(d);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
